// File: rtl/uart_alu_interface.sv
// uart_alu_interface: collects operand A, operand B and opcode bytes from the UART
// receiver, drives them onto the combinational ALU, captures the result and requests
// one transmission. One RX->ALU->TX transaction is in flight at a time. An optional
// inter-byte timeout aborts half-received transactions.
module uart_alu_interface #(
    parameter int NB_DATA    = 8,
    parameter int NB_OP      = 6,
    parameter int NB_STATE   = 3,
    parameter int N_TIMEOUT  = 0,
    parameter int NB_TIMEOUT = 16
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_rx_done_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done_tick,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_error
);

    typedef enum logic [NB_STATE-1:0] {
        ST_WAIT_A,
        ST_WAIT_B,
        ST_WAIT_OP,
        ST_COMPUTE,
        ST_SEND,
        ST_WAIT_TX
    } state_t;

    // A zero timeout disables the abort path entirely; the counter then stays at 0.
    localparam logic                  TIMEOUT_EN       = (N_TIMEOUT > 0);
    localparam int                    TIMEOUT_LAST_INT = (N_TIMEOUT > 0) ? (N_TIMEOUT - 1) : 0;
    localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST     = TIMEOUT_LAST_INT[NB_TIMEOUT-1:0];

    state_t                state_q, state_d;
    logic                  rx_prev_q;
    logic [NB_DATA-1:0]    alu_a_q, alu_a_d;
    logic [NB_DATA-1:0]    alu_b_q, alu_b_d;
    logic [NB_OP-1:0]      alu_op_q, alu_op_d;
    logic [NB_DATA-1:0]    tx_data_q, tx_data_d;
    logic                  error_q, error_d;
    logic [NB_TIMEOUT-1:0] timer_q, timer_d;

    logic accept;
    logic timeout_hit;
    logic collecting;

    // Rising edge of the receiver done flag: a held-high flag counts as one byte.
    assign accept      = i_rx_done_tick & ~rx_prev_q;
    assign collecting  = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
    assign timeout_hit = TIMEOUT_EN && collecting && (timer_q == TIMEOUT_LAST) && !accept;

    // Next-state, operand latching, drop detection and timeout counter.
    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        tx_data_d = tx_data_q;
        error_d   = 1'b0;
        timer_d   = '0;

        if (TIMEOUT_EN && collecting && !accept) begin
            timer_d = timer_q + NB_TIMEOUT'(1);
        end

        case (state_q)
            ST_WAIT_A: begin
                if (accept) begin
                    alu_a_d = i_rx_data;
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (accept) begin
                    alu_b_d = i_rx_data;
                    state_d = ST_WAIT_OP;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = ST_WAIT_A;
                end
            end
            ST_WAIT_OP: begin
                if (accept) begin
                    alu_op_d = i_rx_data[NB_OP-1:0];
                    state_d  = ST_COMPUTE;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = ST_WAIT_A;
                end
            end
            ST_COMPUTE: begin
                tx_data_d = i_alu_result;
                error_d   = accept;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                error_d = accept;
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                error_d = accept;
                if (i_tx_done_tick) begin
                    state_d = ST_WAIT_A;
                end
            end
            default: begin
                state_d = ST_WAIT_A;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial transaction.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_WAIT_A;
            rx_prev_q <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            tx_data_q <= '0;
            error_q   <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            rx_prev_q <= i_rx_done_tick;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            tx_data_q <= tx_data_d;
            error_q   <= error_d;
            timer_q   <= timer_d;
        end
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = (state_q == ST_SEND);
    assign o_busy     = (state_q != ST_WAIT_A);
    assign o_error    = error_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Scoreboard bench for uart_alu_interface: the driver pushes the expected
// operands/result/start cycle for each full transaction; a monitor pops and
// compares on every o_tx_start pulse and counts o_error pulses.
module tb_uart_alu_interface;

    localparam int N_TIMEOUT = 100;

    logic       clk;
    logic       rst_n;
    logic       rx_done;
    logic [7:0] rx_data;
    logic [7:0] alu_result;
    logic       tx_done;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic       o_busy;
    logic       o_error;

    uart_alu_interface #(
        .NB_DATA   (8),
        .NB_OP     (6),
        .NB_STATE  (3),
        .N_TIMEOUT (N_TIMEOUT),
        .NB_TIMEOUT(16)
    ) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_rx_done_tick(rx_done),
        .i_rx_data     (rx_data),
        .i_alu_result  (alu_result),
        .i_tx_done_tick(tx_done),
        .o_alu_a       (o_alu_a),
        .o_alu_b       (o_alu_b),
        .o_alu_op      (o_alu_op),
        .o_tx_start    (o_tx_start),
        .o_tx_data     (o_tx_data),
        .o_busy        (o_busy),
        .o_error       (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] res;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   starts_seen = 0;
    int   err_count   = 0;
    int   err_cyc     = 0;
    int   exp_err     = 0;
    int   txn_no      = 0;

    // Small MIPS-flavoured ALU used both as the DUT's attached ALU and as the reference.
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return 8'($signed(a) >>> b[2:0]);
            6'h02:   return a >> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_result = alu_ref(o_alu_a, o_alu_b, o_alu_op);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare each transmitted result against the oldest expected entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (o_tx_start) begin
                starts_seen++;
                if (sb_q.size() == 0) begin
                    check("unexpected_tx_start", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    txn_no++;
                    $display("txn %0d: a=%h b=%h op=%h tx_data=%h (expect res=%h) cycle=%0d",
                             txn_no, o_alu_a, o_alu_b, o_alu_op, o_tx_data, e.res, cyc);
                    check("alu_a", 32'(o_alu_a), 32'(e.a));
                    check("alu_b", 32'(o_alu_b), 32'(e.b));
                    check("alu_op", 32'(o_alu_op), 32'(e.op));
                    check("tx_data", 32'(o_tx_data), 32'(e.res));
                    check("tx_start_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (o_error) begin
                err_count++;
                err_cyc = cyc;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input int hold, input int gap,
                             input bit push_en, input exp_t e, output int drive_cyc);
        exp_t ex;
        @(negedge clk);
        rx_data   = d;
        rx_done   = 1'b1;
        drive_cyc = cyc;
        if (push_en) begin
            ex     = e;
            ex.cyc = cyc + 2;
            sb_q.push_back(ex);
        end
        repeat (hold) @(negedge clk);
        rx_done = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input int hold_a, input bit drop);
        exp_t e;
        int   dc;
        int   s0;
        bit   seen;
        s0    = starts_seen;
        e.a   = a;
        e.b   = b;
        e.op  = opb[5:0];
        e.res = alu_ref(a, b, opb[5:0]);
        e.cyc = 0;
        send_byte(a, hold_a, $urandom_range(0, 4), 1'b0, e, dc);
        if (hold_a > 4) check("alu_a_after_hold", 32'(o_alu_a), 32'(a));
        send_byte(b, $urandom_range(1, 3), $urandom_range(0, 4), 1'b0, e, dc);
        send_byte(opb, $urandom_range(1, 3), 0, 1'b1, e, dc);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (starts_seen > s0) seen = 1'b1;
        end
        check("tx_start_seen", 32'(seen), 32'd1);
        if (drop) begin
            send_byte(8'($urandom), 1, 1, 1'b0, e, dc);
            exp_err++;
        end
        repeat ($urandom_range(0, 4)) @(negedge clk);
        check("busy_in_wait_tx", 32'(o_busy), 32'd1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
        check("busy_after_tx_done", 32'(o_busy), 32'd0);
        check("tx_data_held", 32'(o_tx_data), 32'(e.res));
        check("error_count", 32'(err_count), 32'(exp_err));
    endtask

    logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : driver
        exp_t e;
        int   dc;
        int   e0;
        bit   seen;
        logic [7:0] opb;
        e       = '{default: '0};
        rst_n   = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_alu_a", 32'(o_alu_a), 32'd0);
        check("reset_tx_start", 32'(o_tx_start), 32'd0);
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_error", 32'(o_error), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: ADD 5+3, held done flag, opcode upper bits, drop during WAIT_TX.
        do_txn(8'h05, 8'h03, 8'h20, 1, 1'b0);
        do_txn(8'hAA, 8'h0F, 8'h24, 16, 1'b0);
        do_txn(8'h40, 8'h10, 8'hE2, 1, 1'b0);
        do_txn(8'h12, 8'h34, 8'h26, 1, 1'b1);

        // Timeout after a single byte, then a normal transaction.
        e0 = err_count;
        send_byte(8'h11, 1, 0, 1'b0, e, dc);
        seen = 1'b0;
        for (int i = 0; i < 150 && !seen; i++) begin
            @(negedge clk);
            if (err_count > e0) seen = 1'b1;
        end
        check("timeout_error_seen", 32'(seen), 32'd1);
        check("timeout_latency", 32'(err_cyc - dc), 32'd101);
        check("timeout_busy", 32'(o_busy), 32'd0);
        exp_err++;
        do_txn(8'h01, 8'h02, 8'h24, 1, 1'b0);

        // Asynchronous reset after the second byte.
        send_byte(8'h77, 1, 1, 1'b0, e, dc);
        send_byte(8'h66, 1, 1, 1'b0, e, dc);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_alu_a", 32'(o_alu_a), 32'd0);
        check("async_rst_alu_b", 32'(o_alu_b), 32'd0);
        check("async_rst_alu_op", 32'(o_alu_op), 32'd0);
        check("async_rst_tx_data", 32'(o_tx_data), 32'd0);
        check("async_rst_busy", 32'(o_busy), 32'd0);
        check("async_rst_error", 32'(o_error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(8'h09, 8'h04, 8'h22, 1, 1'b0);

        // Randomized transactions.
        for (int n = 0; n < 24; n++) begin
            opb = {2'($urandom), ops[$urandom_range(0, 7)]};
            do_txn(8'($urandom), 8'($urandom), opb, $urandom_range(1, 3),
                   ($urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        check("final_error_count", 32'(err_count), 32'(exp_err));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
